// File: rtl/tone_sequencer.sv
// Square-wave note player driven by an external combinational note ROM.
// Handles note timing, rests, one-shot/loop playback, pause and a done pulse.
module tone_sequencer #(
    parameter int unsigned NOTE_W      = 20,
    parameter int unsigned DUR_W       = 5,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TICK_CYCLES = 3125000,
    parameter int unsigned REST_MAX    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] song_len,
    output logic [ADDR_W-1:0] sheet_index,
    input  logic [NOTE_W-1:0] sheet_note,
    input  logic [DUR_W-1:0]  sheet_dur,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t              state;
    logic [NOTE_W-1:0]   note_r;
    logic [DUR_W-1:0]    dur_r;
    logic [NOTE_W-1:0]   tone_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DUR_W-1:0]    unit_cnt;

    logic                tick_wrap;
    logic                note_end;
    logic                is_rest;
    logic                more_entries;
    logic [DUR_W-1:0]    last_unit;
    logic [NOTE_W-1:0]   half_period;

    // Note-end and tone decode; a zero duration is played as one unit.
    always_comb begin
        tick_wrap    = (tick_cnt == TICK_LAST);
        last_unit    = (dur_r == '0) ? '0 : dur_r - DUR_W'(1);
        note_end     = tick_wrap && (unit_cnt == last_unit);
        is_rest      = (note_r <= NOTE_W'(REST_MAX));
        half_period  = note_r >> 1;
        more_entries = (IDX_W'(sheet_index) + IDX_W'(1)) < IDX_W'(song_len);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sheet_index <= '0;
            speaker     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            note_r      <= '0;
            dur_r       <= '0;
            tone_cnt    <= '0;
            tick_cnt    <= '0;
            unit_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                sheet_index <= '0;
                speaker     <= 1'b0;
                busy        <= 1'b0;
            end else if (start) begin
                sheet_index <= '0;
                speaker     <= 1'b0;
                if (song_len != '0) begin
                    state <= FETCH;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        speaker <= 1'b0;
                    end
                    FETCH: begin
                        note_r   <= sheet_note;
                        dur_r    <= sheet_dur;
                        tone_cnt <= '0;
                        tick_cnt <= '0;
                        unit_cnt <= '0;
                        speaker  <= 1'b0;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        if (pause) begin
                            speaker <= 1'b0;
                        end else if (note_end) begin
                            speaker <= 1'b0;
                            if (more_entries) begin
                                sheet_index <= sheet_index + ADDR_W'(1);
                                state       <= FETCH;
                            end else if (loop_en) begin
                                sheet_index <= '0;
                                state       <= FETCH;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                            if (tick_wrap) begin
                                unit_cnt <= unit_cnt + DUR_W'(1);
                            end
                            // Odd periods spend the extra cycle low.
                            if (is_rest) begin
                                speaker <= 1'b0;
                            end else begin
                                speaker  <= (tone_cnt < half_period);
                                tone_cnt <= (tone_cnt == note_r - NOTE_W'(1)) ?
                                            '0 : tone_cnt + NOTE_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: elapsed-cycle reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized playback.
module tb_tone_sequencer;

    localparam int unsigned NOTE_W = 20;
    localparam int unsigned DUR_W  = 5;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TICK   = 10;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] song_len;
    logic [ADDR_W-1:0] sheet_index;
    logic [NOTE_W-1:0] sheet_note;
    logic [DUR_W-1:0]  sheet_dur;
    logic              speaker;
    logic              busy;
    logic              done;

    logic [NOTE_W-1:0] rom_note [16];
    logic [DUR_W-1:0]  rom_dur  [16];

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    tone_sequencer #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
        .TICK_CYCLES(TICK), .REST_MAX(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_len(song_len), .sheet_index(sheet_index),
        .sheet_note(sheet_note), .sheet_dur(sheet_dur), .speaker(speaker),
        .busy(busy), .done(done)
    );

    assign sheet_note = (sheet_index < ADDR_W'(16)) ? rom_note[sheet_index[3:0]] : '0;
    assign sheet_dur  = (sheet_index < ADDR_W'(16)) ? rom_dur[sheet_index[3:0]]  : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: state 0 idle, 1 fetch, 2 play; m_e counts unpaused play cycles of a note.
    int   m_state = 0;
    int   m_idx   = 0;
    int   m_note  = 0;
    int   m_dur   = 1;
    int   m_e     = 0;
    logic m_spk   = 1'b0;
    logic m_busy  = 1'b0;
    logic m_done  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 0; m_idx <= 0; m_e <= 0;
            m_spk <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (stop) begin
                m_state <= 0; m_idx <= 0; m_spk <= 1'b0; m_busy <= 1'b0;
            end else if (start) begin
                m_idx <= 0; m_spk <= 1'b0;
                if (song_len != 0) begin
                    m_state <= 1; m_busy <= 1'b1;
                end else begin
                    m_state <= 0; m_busy <= 1'b0; m_done <= 1'b1;
                end
            end else if (m_state == 1) begin
                m_note  <= int'(rom_note[m_idx]);
                m_dur   <= (rom_dur[m_idx] == 0) ? 1 : int'(rom_dur[m_idx]);
                m_e     <= 0;
                m_spk   <= 1'b0;
                m_state <= 2;
            end else if (m_state == 2) begin
                if (pause) begin
                    m_spk <= 1'b0;
                end else if (m_e == m_dur * TICK - 1) begin
                    m_spk <= 1'b0;
                    if (m_idx + 1 < int'(song_len)) begin
                        m_idx <= m_idx + 1; m_state <= 1;
                    end else if (loop_en) begin
                        m_idx <= 0; m_state <= 1;
                    end else begin
                        m_state <= 0; m_busy <= 1'b0; m_done <= 1'b1;
                    end
                end else begin
                    m_spk <= (m_note > 1) && ((m_e % m_note) < (m_note / 2));
                    m_e   <= m_e + 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (checking) begin
            checks++;
            if (sheet_index !== ADDR_W'(m_idx) || speaker !== m_spk ||
                busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL model t=%0t idx=%0d exp %0d spk=%b exp %b busy=%b exp %b done=%b exp %b",
                         $time, sheet_index, m_idx, speaker, m_spk, busy, m_busy, done, m_done);
            end
        end
    endtask

    task automatic pin(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Samples from the current negedge until playback is over; optional pause window.
    task automatic run_measure(input int limit, input int pause_at, input int pause_len,
                               output int busy_n, output int done_n, output int hi_n,
                               output int max_hi, output int hi_paused);
        int run;
        bit was_busy;
        busy_n = 0; done_n = 0; hi_n = 0; max_hi = 0; hi_paused = 0;
        run = 0; was_busy = 0;
        for (int i = 0; i < limit; i++) begin
            if (busy) begin busy_n++; was_busy = 1; end
            if (done) done_n++;
            if (speaker) begin
                hi_n++; run++;
                if (run > max_hi) max_hi = run;
                if (i > pause_at && i <= pause_at + pause_len) hi_paused++;
            end else begin
                run = 0;
            end
            if (i == pause_at) pause = 1'b1;
            if (i == pause_at + pause_len) pause = 1'b0;
            if (!busy && (was_busy || done_n > 0)) return;
            tick();
        end
        pause = 1'b0;
        checks++;
        errors++;
        $display("FAIL timeout playback still busy after %0d cycles", limit);
    endtask

    task automatic load_demo();
        for (int i = 0; i < 16; i++) begin rom_note[i] = '0; rom_dur[i] = '0; end
        rom_note[0] = 20'd100; rom_dur[0] = 5'd2;
        rom_note[1] = 20'd1;   rom_dur[1] = 5'd1;
        rom_note[2] = 20'd50;  rom_dur[2] = 5'd3;
    endtask

    int b_n, d_n, h_n, mh, hp;

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        loop_en = 1'b0; song_len = '0;
        load_demo();
        repeat (3) @(negedge clk);
        checking = 1;
        pin("reset_busy", int'(busy), 0);
        pin("reset_speaker", int'(speaker), 0);
        pin("reset_index", int'(sheet_index), 0);
        reset = 1'b0;
        tick();

        // One-shot playback of the demo sheet.
        song_len = ADDR_W'(3);
        pulse_start();
        run_measure(300, -100, 0, b_n, d_n, h_n, mh, hp);
        pin("oneshot_busy_cycles", b_n, 63);
        pin("oneshot_done_pulses", d_n, 1);
        pin("oneshot_high_cycles", h_n, 44);
        pin("oneshot_max_high_run", mh, 25);
        tick();

        // Pause 37 cycles in the middle of the third note.
        pulse_start();
        run_measure(300, 40, 37, b_n, d_n, h_n, mh, hp);
        pin("pause_busy_cycles", b_n, 100);
        pin("pause_speaker_high", hp, 0);
        pin("pause_done_pulses", d_n, 1);
        tick();

        // Loop mode, then drop loop_en to finish at the next sheet end.
        begin
            int wraps = 0;
            int dones = 0;
            int prev  = 0;
            loop_en = 1'b1;
            pulse_start();
            for (int i = 0; i < 150; i++) begin
                if (prev == 2 && sheet_index == ADDR_W'(0)) wraps++;
                if (done) dones++;
                prev = int'(sheet_index);
                tick();
            end
            pin("loop_wrapped", int'(wraps > 0), 1);
            pin("loop_no_done", dones, 0);
            loop_en = 1'b0;
            run_measure(300, -100, 0, b_n, d_n, h_n, mh, hp);
            pin("loop_end_done", d_n, 1);
            tick();
        end

        // Stop and start in the same cycle during PLAY.
        pulse_start();
        repeat (15) tick();
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        pin("collide_busy", int'(busy), 0);
        pin("collide_done", int'(done), 0);
        pin("collide_index", int'(sheet_index), 0);
        tick();
        pin("collide_done_after", int'(done), 0);

        // Zero-duration entry with an odd period of 7.
        rom_note[0] = 20'd7; rom_dur[0] = 5'd0;
        song_len = ADDR_W'(1);
        pulse_start();
        run_measure(100, -100, 0, b_n, d_n, h_n, mh, hp);
        pin("dur0_busy_cycles", b_n, 11);
        pin("note7_high_cycles", h_n, 5);
        pin("note7_max_high_run", mh, 3);
        tick();

        // Empty song: done pulse only.
        song_len = '0;
        pulse_start();
        run_measure(20, -100, 0, b_n, d_n, h_n, mh, hp);
        pin("empty_busy", b_n, 0);
        pin("empty_done", d_n, 1);
        tick();

        // Reset during PLAY.
        load_demo();
        song_len = ADDR_W'(3);
        pulse_start();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pin("midreset_busy", int'(busy), 0);
        pin("midreset_speaker", int'(speaker), 0);
        pin("midreset_index", int'(sheet_index), 0);
        pin("midreset_done", int'(done), 0);
        tick();
        pin("midreset_done_after", int'(done), 0);

        // Randomized sheets and control activity.
        for (int s = 0; s < 25; s++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 5))
                    0: rom_note[i] = 20'd0;
                    1: rom_note[i] = 20'd1;
                    2: rom_note[i] = 20'd2;
                    3: rom_note[i] = 20'd7;
                    default: rom_note[i] = NOTE_W'($urandom_range(3, 40));
                endcase
                rom_dur[i] = DUR_W'($urandom_range(0, 3));
            end
            song_len = ADDR_W'(len);
            loop_en  = 1'($urandom_range(0, 1));
            pulse_start();
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 19) == 0) pause = ~pause;
                stop  = ($urandom_range(0, 299) == 0);
                start = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
                if ($urandom_range(0, 199) == 0) song_len = ADDR_W'($urandom_range(0, 6));
                tick();
                stop = 1'b0; start = 1'b0;
                if (!busy && !pause && c > 2) break;
            end
            pause = 1'b0;
            stop  = 1'b1;
            tick();
            stop = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
